conv_tree_deserializer: RTL and testbench

Downstream companion to `conv_tree_serializer`: receives its one-bit serial stream, realigns it on a frame-start marker and reassembles `OUTPUTS_NUM`-bit parallel words. Completed words are presented on a valid/ready output register to the next consumer. Realignment errors and dropped words are reported through sticky flags.

---
 rtl/conv_tree_pkg.sv | 16 +
 rtl/conv_tree_shift_reg.sv | 38 +++
 rtl/conv_tree_deserializer.sv | 127 ++++++++++++
 tb/tb_conv_tree_deserializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_tree_pkg.sv
// Shared definitions for the conv_tree serializer/deserializer pair.
package conv_tree_pkg;

  localparam int CONV_TREE_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  // The counter must be able to hold the full word width, not just width-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/conv_tree_shift_reg.sv
// MSB-first shift-in register. A load restarts the word with the given bit.
module conv_tree_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = {{(WIDTH-1){1'b0}}, bit_i};
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/conv_tree_deserializer.sv
// Realigns a framed serial stream into parallel words behind a valid/ready
// output register, with sticky overflow and framing-error flags.
module conv_tree_deserializer
  import conv_tree_pkg::*;
#(
  parameter int OUTPUTS_NUM = CONV_TREE_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SERIAL_IN,
  input  logic                   FRAME_START,
  output logic [OUTPUTS_NUM-1:0] PAR_OUT,
  output logic                   PAR_VALID,
  input  logic                   PAR_READY,
  output logic                   OVERFLOW,
  output logic                   FRAME_ERR
);

  localparam int CW = cnt_width(OUTPUTS_NUM);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUTPUTS_NUM);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUTPUTS_NUM - 1);

  conv_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUTPUTS_NUM-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   ferr_q, ferr_d;

  logic                   sr_clr, sr_load, sr_shift, complete;
  logic [OUTPUTS_NUM-1:0] sr_q;
  logic [OUTPUTS_NUM-1:0] word;

  conv_tree_shift_reg #(
    .WIDTH(OUTPUTS_NUM)
  ) u_shift_reg (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr_i  (sr_clr),
    .load_i (sr_load),
    .shift_i(sr_shift),
    .bit_i  (SERIAL_IN),
    .q_o    (sr_q)
  );

  // The completing bit is still on SERIAL_IN, so the word is formed here.
  assign word = {sr_q[OUTPUTS_NUM-2:0], SERIAL_IN};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ferr_d   = ferr_q;
    sr_clr   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          sr_load = 1'b1;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (FRAME_START) begin
          // Either a back-to-back word or a resync over a partial word.
          sr_load = 1'b1;
          cnt_d   = CW'(1);
          if (cnt_q != CNT_FULL) ferr_d = 1'b1;
        end else if (cnt_q == CNT_FULL) begin
          sr_clr  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          complete = (cnt_q == CNT_LAST);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (complete) begin
      if (!valid_q || PAR_READY) begin
        out_d   = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && PAR_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign PAR_OUT   = out_q;
  assign PAR_VALID = valid_q;
  assign OVERFLOW  = ovf_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_conv_tree_deserializer.sv
// Directed and randomized bench for conv_tree_deserializer with a
// frame-history reference model.
module tb_conv_tree_deserializer;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sin = 1'b0;
  logic         fs = 1'b0;
  logic         rdy = 1'b0;
  logic [N-1:0] par_out;
  logic         par_valid;
  logic         ovf;
  logic         ferr;

  int checks = 0;
  int errors = 0;

  // Reference model: a word is any N-bit window that begins on a frame-start
  // bit with no further frame start inside it.
  bit           hfs[$];
  bit           hsin[$];
  logic [N-1:0] m_out;
  logic         m_valid;
  logic         m_ovf;
  logic         m_ferr;

  conv_tree_deserializer #(.OUTPUTS_NUM(N)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .SERIAL_IN  (sin),
    .FRAME_START(fs),
    .PAR_OUT    (par_out),
    .PAR_VALID  (par_valid),
    .PAR_READY  (rdy),
    .OVERFLOW   (ovf),
    .FRAME_ERR  (ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hfs.delete();
    hsin.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic model_edge(input bit f, input bit s, input bit r);
    int n;
    bit done;
    logic [N-1:0] w;
    hfs.push_back(f);
    hsin.push_back(s);
    if (hfs.size() > N) begin
      void'(hfs.pop_front());
      void'(hsin.pop_front());
    end
    n = hfs.size();
    if (f) begin
      for (int k = 0; k < n - 1; k++) if (hfs[k]) m_ferr = 1'b1;
    end
    done = (n == N) && hfs[0];
    for (int k = 1; k < n; k++) if (hfs[k]) done = 1'b0;
    if (done) begin
      for (int k = 0; k < N; k++) w[N-1-k] = hsin[k];
      if (!m_valid || r) begin
        m_out   = w;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(par_valid), 32'(m_valid));
    check({tag, ".out"},   32'(par_out),   32'(m_out));
    check({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
    check({tag, ".ferr"},  32'(ferr),      32'(m_ferr));
  endtask

  task automatic step(input bit f, input bit s, input bit r);
    fs  = f;
    sin = s;
    rdy = r;
    @(posedge clk);
    model_edge(f, s, r);
    #1;
    check_all("step");
  endtask

  task automatic send_word(input logic [N-1:0] w, input int len, input int rdy_pct);
    for (int i = 0; i < len; i++)
      step(i == 0, w[N-1-i], $urandom_range(99) < rdy_pct);
  endtask

  task automatic idle(input int cycles, input int rdy_pct);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 1'($urandom_range(1)), $urandom_range(99) < rdy_pct);
  endtask

  task automatic do_reset();
    #4;
    rst_n = 1'b0;
    fs    = 1'b0;
    #1;
    model_clear();
    check("rst.valid", 32'(par_valid), 32'd0);
    check("rst.out",   32'(par_out),   32'd0);
    check("rst.ovf",   32'(ovf),       32'd0);
    check("rst.ferr",  32'(ferr),      32'd0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // Single word, consumer always ready
    send_word(16'hC5AF, N, 100);
    check("single.valid", 32'(par_valid), 32'd1);
    check("single.out",   32'(par_out),   32'hC5AF);
    idle(1, 100);
    check("single.pulse", 32'(par_valid), 32'd0);
    idle(3, 100);
    check("single.flags", 32'({ovf, ferr}), 32'd0);

    // Back-to-back words
    do_reset();
    send_word(16'hC5AF, N, 100);
    check("b2b.w0", 32'(par_out), 32'hC5AF);
    send_word(16'h0000, N, 100);
    check("b2b.w1", 32'(par_out), 32'h0000);
    check("b2b.v1", 32'(par_valid), 32'd1);
    idle(2, 100);
    check("b2b.flags", 32'({ovf, ferr}), 32'd0);

    // Backpressure: second word dropped
    do_reset();
    send_word(16'hC5AF, N, 0);
    check("bp.ovf0", 32'(ovf), 32'd0);
    send_word(16'h1234, N, 0);
    check("bp.out",   32'(par_out),   32'hC5AF);
    check("bp.valid", 32'(par_valid), 32'd1);
    check("bp.ovf",   32'(ovf),       32'd1);
    idle(2, 100);
    check("bp.sticky", 32'(ovf), 32'd1);

    // Completion and acceptance on the same edge
    do_reset();
    send_word(16'hC5AF, N, 0);
    send_word(16'h3C96, N - 1, 0);
    step(1'b0, 1'b0, 1'b1);
    check("sim.valid", 32'(par_valid), 32'd1);
    check("sim.out",   32'(par_out),   32'h3C96);
    check("sim.ovf",   32'(ovf),       32'd0);

    // Resync after five bits
    do_reset();
    send_word(16'hFFFF, 5, 100);
    send_word(16'hA5A5, N, 100);
    check("resync.ferr", 32'(ferr),    32'd1);
    check("resync.out",  32'(par_out), 32'hA5A5);

    // Reset mid-word, unframed bits ignored, then a clean word
    do_reset();
    send_word(16'hBEEF, 8, 100);
    do_reset();
    idle(N + 4, 100);
    check("rstmid.novalid", 32'(par_valid), 32'd0);
    send_word(16'h5A3C, N, 100);
    check("rstmid.out", 32'(par_out), 32'h5A3C);

    // Randomized framing, truncations, gaps and backpressure
    do_reset();
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(3), 70);
      if ($urandom_range(7) == 0)
        send_word(N'($urandom), $urandom_range(1, N - 1), 70);
      else
        send_word(N'($urandom), N, 70);
    end
    idle(N + 2, 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
